// File: rtl/corr_out_fifo.sv
// Correlator output capture FIFO: timestamps detections (every cycle or the peak
// |in| of each detect burst) into a first-word-fall-through queue with sticky overflow.
module corr_out_fifo #(
   parameter int unsigned W         = 14,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned TSW       = 16,
   parameter int unsigned PEAK_MODE = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ena,
   input  logic [W-1:0]                 in,
   input  logic                         detect,
   input  logic                         out_ready,
   input  logic                         clr_ovf,
   output logic                         out_valid,
   output logic [W-1:0]                 out,
   output logic [TSW-1:0]               out_ts,
   output logic [$clog2(DEPTH):0]       level,
   output logic                         ovf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      TRACK = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    peak_q, peak_d;
   logic [TSW-1:0]  peak_ts_q, peak_ts_d;
   logic [TSW-1:0]  ts_q, ts_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            ovf_q, ovf_d;
   logic [W-1:0]    mem_q [DEPTH];
   logic [W-1:0]    mem_d [DEPTH];
   logic [TSW-1:0]  mem_ts_q [DEPTH];
   logic [TSW-1:0]  mem_ts_d [DEPTH];

   logic            push_req;
   logic [W-1:0]    push_data;
   logic [TSW-1:0]  push_ts;
   logic            empty, full, pop, push, ovf_set;

   // Magnitude one bit wider than the sample so the most negative value is representable.
   function automatic logic [W:0] mag(input logic [W-1:0] x);
      logic [W:0] xe;
      xe = {x[W-1], x};
      return xe[W] ? (W+1)'(~xe + (W+1)'(1)) : xe;
   endfunction

   // Capture selection: direct per-cycle push, or peak tracking across a detect burst.
   always_comb begin
      state_d   = state_q;
      peak_d    = peak_q;
      peak_ts_d = peak_ts_q;
      push_req  = 1'b0;
      push_data = in;
      push_ts   = ts_q;
      ts_d      = ena ? TSW'(ts_q + TSW'(1)) : ts_q;
      if (PEAK_MODE == 0) begin
         push_req = ena & detect;
      end else if (ena) begin
         case (state_q)
            IDLE: begin
               if (detect) begin
                  state_d   = TRACK;
                  peak_d    = in;
                  peak_ts_d = ts_q;
               end
            end
            TRACK: begin
               if (detect) begin
                  if (mag(in) > mag(peak_q)) begin
                     peak_d    = in;
                     peak_ts_d = ts_q;
                  end
               end else begin
                  push_req  = 1'b1;
                  push_data = peak_q;
                  push_ts   = peak_ts_q;
                  state_d   = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // FIFO bookkeeping; a pop frees the slot for a same-cycle push even when full.
   always_comb begin
      empty    = (level_q == '0);
      full     = (level_q == LW'(DEPTH));
      pop      = out_ready & ~empty;
      push     = push_req & (~full | pop);
      ovf_set  = push_req & full & ~pop;
      level_d  = LW'(level_q + LW'(push) - LW'(pop));
      wr_ptr_d = push ? AW'(wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d = pop  ? AW'(rd_ptr_q + AW'(1)) : rd_ptr_q;
      ovf_d    = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
      mem_d    = mem_q;
      mem_ts_d = mem_ts_q;
      if (push) begin
         mem_d[wr_ptr_q]    = push_data;
         mem_ts_d[wr_ptr_q] = push_ts;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         peak_q    <= '0;
         peak_ts_q <= '0;
         ts_q      <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         peak_q    <= peak_d;
         peak_ts_q <= peak_ts_d;
         ts_q      <= ts_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         ovf_q     <= ovf_d;
      end
   end

   // Storage is not reset; validity is tracked by the pointers and level alone.
   always_ff @(posedge clk) begin
      mem_q    <= mem_d;
      mem_ts_q <= mem_ts_d;
   end

   assign out_valid = ~empty;
   assign out       = empty ? '0 : mem_q[rd_ptr_q];
   assign out_ts    = empty ? '0 : mem_ts_q[rd_ptr_q];
   assign level     = level_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_corr_out_fifo.sv
// Directed bench for corr_out_fifo: per-cycle capture, peak capture, and a narrow
// timestamp / two-entry instance for wrap behaviour.
module tb_corr_out_fifo;

   logic        clk = 1'b0;
   logic        rst, ena, detect, out_ready, clr_ovf;
   logic [13:0] din;

   logic        v0, v1, v2;
   logic [13:0] o0, o1, o2;
   logic [15:0] t0, t1;
   logic [3:0]  t2;
   logic [2:0]  l0, l1;
   logic [1:0]  l2;
   logic        f0, f1, f2;

   int n_chk = 0;
   int n_err = 0;

   corr_out_fifo #(.W(14), .DEPTH(4), .TSW(16), .PEAK_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .ena(ena), .in(din), .detect(detect), .out_ready(out_ready),
      .clr_ovf(clr_ovf), .out_valid(v0), .out(o0), .out_ts(t0), .level(l0), .ovf(f0));

   corr_out_fifo #(.W(14), .DEPTH(4), .TSW(16), .PEAK_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .ena(ena), .in(din), .detect(detect), .out_ready(out_ready),
      .clr_ovf(clr_ovf), .out_valid(v1), .out(o1), .out_ts(t1), .level(l1), .ovf(f1));

   corr_out_fifo #(.W(14), .DEPTH(2), .TSW(4), .PEAK_MODE(0)) dut2 (
      .clk(clk), .rst(rst), .ena(ena), .in(din), .detect(detect), .out_ready(out_ready),
      .clr_ovf(clr_ovf), .out_valid(v2), .out(o2), .out_ts(t2), .level(l2), .ovf(f2));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; ena = 1'b0; detect = 1'b0; din = '0; out_ready = 1'b0; clr_ovf = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (v0 !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b expected 0", v0); end
      n_chk++; if (l0 !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d expected 0", l0); end
      n_chk++; if (o0 !== 14'd0) begin n_err++; $display("FAIL reset_out got %0d expected 0", o0); end
      n_chk++; if (t0 !== 16'd0) begin n_err++; $display("FAIL reset_ts got %0d expected 0", t0); end
      n_chk++; if (f0 !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b expected 0", f0); end
      n_chk++; if (l1 !== 3'd0) begin n_err++; $display("FAIL reset_level_pk got %0d expected 0", l1); end
   endtask

   task automatic test_basic();
      do_reset();
      ena = 1'b1;
      repeat (3) step();
      detect = 1'b1; din = 14'd100;
      step();
      detect = 1'b0;
      n_chk++; if (v0 !== 1'b1) begin n_err++; $display("FAIL basic_latency got %0b expected 1", v0); end
      step();
      detect = 1'b1; din = 14'(-7);
      step();
      detect = 1'b0;
      n_chk++; if (l0 !== 3'd2) begin n_err++; $display("FAIL basic_level got %0d expected 2", l0); end
      n_chk++; if (o0 !== 14'd100) begin n_err++; $display("FAIL basic_out got %0d expected 100", $signed(o0)); end
      n_chk++; if (t0 !== 16'd3) begin n_err++; $display("FAIL basic_ts got %0d expected 3", t0); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_chk++; if (o0 !== 14'(-7)) begin n_err++; $display("FAIL basic_pop_out got %0d expected -7", $signed(o0)); end
      n_chk++; if (t0 !== 16'd5) begin n_err++; $display("FAIL basic_pop_ts got %0d expected 5", t0); end
      n_chk++; if (l0 !== 3'd1) begin n_err++; $display("FAIL basic_pop_level got %0d expected 1", l0); end
      out_ready = 1'b1;
      step();
      n_chk++; if (v0 !== 1'b0) begin n_err++; $display("FAIL empty_valid got %0b expected 0", v0); end
      n_chk++; if (o0 !== 14'd0) begin n_err++; $display("FAIL empty_out got %0d expected 0", $signed(o0)); end
      n_chk++; if (t0 !== 16'd0) begin n_err++; $display("FAIL empty_ts got %0d expected 0", t0); end
      step();
      out_ready = 1'b0;
      n_chk++; if (l0 !== 3'd0) begin n_err++; $display("FAIL underflow_level got %0d expected 0", l0); end
   endtask

   task automatic test_overflow();
      int exp_v[4];
      int exp_t[4];
      exp_v = '{2, 3, 4, 9};
      exp_t = '{1, 2, 3, 6};
      do_reset();
      ena = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         detect = 1'b1; din = 14'(i);
         step();
      end
      detect = 1'b0;
      n_chk++; if (l0 !== 3'd4) begin n_err++; $display("FAIL ovf_level got %0d expected 4", l0); end
      n_chk++; if (f0 !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0b expected 1", f0); end
      n_chk++; if (o0 !== 14'd1) begin n_err++; $display("FAIL ovf_head got %0d expected 1", $signed(o0)); end
      n_chk++; if (t0 !== 16'd0) begin n_err++; $display("FAIL ovf_head_ts got %0d expected 0", t0); end
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      n_chk++; if (f0 !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %0b expected 0", f0); end
      detect = 1'b1; din = 14'd9; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_chk++; if (l0 !== 3'd4) begin n_err++; $display("FAIL fullpp_level got %0d expected 4", l0); end
      n_chk++; if (o0 !== 14'd2) begin n_err++; $display("FAIL fullpp_head got %0d expected 2", $signed(o0)); end
      n_chk++; if (f0 !== 1'b0) begin n_err++; $display("FAIL fullpp_ovf got %0b expected 0", f0); end
      din = 14'd11; clr_ovf = 1'b1;
      step();
      detect = 1'b0; clr_ovf = 1'b0;
      n_chk++; if (f0 !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins got %0b expected 1", f0); end
      n_chk++; if (o0 !== 14'd2) begin n_err++; $display("FAIL ovf_keep_head got %0d expected 2", $signed(o0)); end
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      n_chk++; if (f0 !== 1'b0) begin n_err++; $display("FAIL ovf_clear2 got %0b expected 0", f0); end
      for (int i = 0; i < 4; i++) begin
         n_chk++; if (o0 !== 14'(exp_v[i])) begin n_err++; $display("FAIL drain_out[%0d] got %0d expected %0d", i, $signed(o0), exp_v[i]); end
         n_chk++; if (t0 !== 16'(exp_t[i])) begin n_err++; $display("FAIL drain_ts[%0d] got %0d expected %0d", i, t0, exp_t[i]); end
         out_ready = 1'b1;
         step();
      end
      out_ready = 1'b0;
      n_chk++; if (l0 !== 3'd0) begin n_err++; $display("FAIL drain_level got %0d expected 0", l0); end
   endtask

   task automatic test_wrap();
      do_reset();
      ena = 1'b1;
      repeat (15) step();
      detect = 1'b1; din = 14'd21;
      step();
      din = 14'd22;
      step();
      detect = 1'b0;
      n_chk++; if (l2 !== 2'd2) begin n_err++; $display("FAIL wrap_level got %0d expected 2", l2); end
      n_chk++; if (o2 !== 14'd21) begin n_err++; $display("FAIL wrap_out got %0d expected 21", $signed(o2)); end
      n_chk++; if (t2 !== 4'd15) begin n_err++; $display("FAIL wrap_ts_max got %0d expected 15", t2); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_chk++; if (o2 !== 14'd22) begin n_err++; $display("FAIL wrap_out2 got %0d expected 22", $signed(o2)); end
      n_chk++; if (t2 !== 4'd0) begin n_err++; $display("FAIL wrap_ts_zero got %0d expected 0", t2); end
      ena = 1'b0; detect = 1'b1; din = 14'd5;
      repeat (3) step();
      n_chk++; if (l2 !== 2'd1) begin n_err++; $display("FAIL ena_gate_level got %0d expected 1", l2); end
      ena = 1'b1; din = 14'd6;
      step();
      detect = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_chk++; if (o2 !== 14'd6) begin n_err++; $display("FAIL ptr_wrap_out got %0d expected 6", $signed(o2)); end
      n_chk++; if (t2 !== 4'd2) begin n_err++; $display("FAIL ts_freeze got %0d expected 2", t2); end
   endtask

   task automatic test_peak();
      do_reset();
      ena = 1'b1;
      repeat (8) step();
      detect = 1'b1;
      din = 14'd10;   step();
      din = 14'(-30); step();
      din = 14'd30;   step();
      din = 14'd25;   step();
      n_chk++; if (l1 !== 3'd0) begin n_err++; $display("FAIL peak_midburst_level got %0d expected 0", l1); end
      detect = 1'b0; din = 14'(-5000);
      step();
      n_chk++; if (l1 !== 3'd1) begin n_err++; $display("FAIL peak_level got %0d expected 1", l1); end
      n_chk++; if (o1 !== 14'(-30)) begin n_err++; $display("FAIL peak_out got %0d expected -30", $signed(o1)); end
      n_chk++; if (t1 !== 16'd9) begin n_err++; $display("FAIL peak_ts got %0d expected 9", t1); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_chk++; if (l1 !== 3'd0) begin n_err++; $display("FAIL peak_pop_level got %0d expected 0", l1); end
   endtask

   task automatic test_peak_extreme();
      do_reset();
      ena = 1'b1;
      detect = 1'b1; din = 14'd8191;  step();
      din = 14'(-8192);               step();
      ena = 1'b0; detect = 1'b0; din = '0;
      repeat (3) step();
      n_chk++; if (l1 !== 3'd0) begin n_err++; $display("FAIL ext_frozen_level got %0d expected 0", l1); end
      ena = 1'b1; detect = 1'b1; din = 14'd8191;
      step();
      detect = 1'b0; din = '0;
      step();
      n_chk++; if (l1 !== 3'd1) begin n_err++; $display("FAIL ext_level got %0d expected 1", l1); end
      n_chk++; if (o1 !== 14'(-8192)) begin n_err++; $display("FAIL ext_out got %0d expected -8192", $signed(o1)); end
      n_chk++; if (t1 !== 16'd1) begin n_err++; $display("FAIL ext_ts got %0d expected 1", t1); end
      detect = 1'b1; din = 14'd5; step();
      din = 14'(-5);              step();
      detect = 1'b0;              step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_chk++; if (o1 !== 14'd5) begin n_err++; $display("FAIL tie_out got %0d expected 5", $signed(o1)); end
      n_chk++; if (t1 !== 16'd4) begin n_err++; $display("FAIL tie_ts got %0d expected 4", t1); end
   endtask

   task automatic test_rst_track();
      do_reset();
      ena = 1'b1;
      detect = 1'b1; din = 14'd1; step();
      detect = 1'b0;              step();
      detect = 1'b1; din = 14'd2; step();
      detect = 1'b0;              step();
      n_chk++; if (l1 !== 3'd2) begin n_err++; $display("FAIL rt_pre_level got %0d expected 2", l1); end
      detect = 1'b1; din = 14'd3;
      step();
      rst = 1'b1; detect = 1'b0;
      step();
      rst = 1'b0;
      n_chk++; if (l1 !== 3'd0) begin n_err++; $display("FAIL rt_level got %0d expected 0", l1); end
      n_chk++; if (v1 !== 1'b0) begin n_err++; $display("FAIL rt_valid got %0b expected 0", v1); end
      repeat (2) step();
      n_chk++; if (l1 !== 3'd0) begin n_err++; $display("FAIL rt_discard got %0d expected 0", l1); end
      detect = 1'b1; din = 14'd7;
      step();
      detect = 1'b0; din = '0;
      step();
      n_chk++; if (l1 !== 3'd1) begin n_err++; $display("FAIL rt_new_level got %0d expected 1", l1); end
      n_chk++; if (o1 !== 14'd7) begin n_err++; $display("FAIL rt_new_out got %0d expected 7", $signed(o1)); end
      n_chk++; if (t1 !== 16'd2) begin n_err++; $display("FAIL rt_new_ts got %0d expected 2", t1); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_wrap();
      test_peak();
      test_peak_extreme();
      test_rst_track();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/corr_out_fifo.md
CORR_OUT_FIFO -- requirements
Module: corr_out_fifo

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  W  14  sample width, signed two's complement
  DEPTH  4  FIFO entries, power of two, >= 2
  TSW  16  timestamp width
  PEAK_MODE  0  0 = capture every detect cycle; 1 = capture peak |in| per detect burst
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  reset, synchronous, active-high
  ena  in  1  clock enable for sampling, capture, timestamp
  in  in  W  signed correlator sample
  detect  in  1  detection strobe, qualified by ena
  out_ready  in  1  consumer accepts head entry
  clr_ovf  in  1  clears sticky overflow
  out_valid  out  1  FIFO non-empty
  out  out  W  signed head sample
  out_ts  out  TSW  head timestamp
  level  out  clog2(DEPTH)+1  current occupancy
  ovf  out  1  sticky overflow flag
REQ-003 Reset SHALL be synchronous and active-high on rst; there SHALL be exactly one clock, clk.

Function
REQ-004 Timestamp counter ts SHALL increment by 1 on every clk edge with ena=1, wrap from 2^TSW-1 to 0, hold when ena=0.
REQ-005 A captured entry SHALL carry the ts value of the cycle in which its sample was present on in (pre-increment).
REQ-006 PEAK_MODE=0: every cycle with ena=1 and detect=1 SHALL push {in, ts}.
REQ-007 PEAK_MODE=1: FSM states IDLE, TRACK; IDLE + ena&detect -> TRACK, load peak=in, peak_ts=ts.
REQ-008 TRACK + ena&detect: replace peak/peak_ts only if |in| > |peak| (strict; earliest wins on ties).
REQ-009 TRACK + ena&!detect: push {peak, peak_ts}, -> IDLE; the closing cycle's in is not compared.
REQ-010 Magnitudes SHALL be computed at W+1 bits so |-2^(W-1)| = 2^(W-1) compares correctly.
REQ-011 ena=0 SHALL freeze ts, FSM, peak registers and capture; pop handshake SHALL remain active.
REQ-012 FIFO SHALL be first-word-fall-through: out_valid = (level != 0); out/out_ts show head entry; out/out_ts = 0 when empty.
REQ-013 Pop SHALL occur on a cycle with out_valid=1 and out_ready=1; head advances at that edge.
REQ-014 Capture-to-out_valid latency SHALL be 1 cycle into an empty FIFO (mode 0: detect cycle N -> out_valid at N+1).
REQ-015 Push and pop same cycle SHALL both complete; level unchanged, including when full.
REQ-016 Push when full without pop SHALL drop the new entry, keep contents, set ovf=1.
REQ-017 Pop when empty SHALL be ignored; level never underflows.
REQ-018 Read/write pointers SHALL wrap modulo DEPTH.
REQ-019 ovf SHALL stay 1 until clr_ovf=1 or rst; overflow and clr_ovf same cycle -> ovf=1 (set wins).

Reset
REQ-020 rst=1 at a clk edge SHALL set ts=0, level=0, out_valid=0, out=0, out_ts=0, ovf=0, FSM=IDLE, peak=0.
REQ-021 rst SHALL take priority over ena, detect, out_ready, clr_ovf; a TRACK burst in progress SHALL be discarded, not pushed.
REQ-022 FIFO storage contents need not be cleared; only pointers and level.

Verification
REQ-023 Mode 0, out_ready=0, ena=1; detect at ts=3,5 with in=100,-7 -> level=2, out=100, out_ts=3; pulse out_ready one cycle -> out=-7, out_ts=5, level=1.
REQ-024 Mode 0, DEPTH=4, out_ready=0, 5 consecutive detects in=1..5 -> level=4, ovf=1, FIFO holds 1..4; clr_ovf -> ovf=0.
REQ-025 Full FIFO, out_ready=1 and detect=1 same cycle -> level stays 4, head advances, ovf stays 0.
REQ-026 Mode 1, burst in=10,-30,30,25 at ts=8..11, detect low at ts=12 -> one entry out=-30, out_ts=9.
REQ-027 Mode 1, in=-8192 (W=14) within burst vs 8191 -> -8192 captured; ena=0 mid-burst for 3 cycles -> ts frozen, same result.
REQ-028 rst asserted during TRACK with level=2 -> next cycle level=0, out_valid=0, ts=0, no entry pushed after rst release until a new burst ends.
